bf_writeback: RTL and testbench

Write-back stage for the radix-2 butterfly processing element. It captures the two butterfly results (`bf_lower`, `bf_upper`) a fixed `PE_LAT` cycles after each butterfly is issued. It routes each result to one of two single-write-port coefficient banks by address parity, and absorbs bank conflicts in a small pending FIFO. It also reports when a full NTT/INTT stage has been committed to memory, which is the signal the stage controller waits on before issuing the next stage.

---
 rtl/bf_writeback.sv | 195 +++++++++++++++++++
 tb/tb_bf_writeback.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_writeback.sv
// Butterfly write-back stage. Results are paired with their issue tags, split
// across two single-port banks by address parity, and any bank conflicts are
// parked in a small pending FIFO. Also reports when a stage is fully committed.
module bf_writeback #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 8,
    parameter int PE_LAT     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sel,
    input  logic                  in_last,
    input  logic [ADDR_WIDTH-1:0] in_addr_u,
    input  logic [ADDR_WIDTH-1:0] in_addr_v,
    input  logic [DATA_WIDTH-1:0] bf_lower,
    input  logic [DATA_WIDTH-1:0] bf_upper,
    output logic                  wr0_en,
    output logic [ADDR_WIDTH-2:0] wr0_addr,
    output logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr1_en,
    output logic [ADDR_WIDTH-2:0] wr1_addr,
    output logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  idle,
    output logic                  stage_done,
    output logic                  mode_err,
    output logic                  ovf_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PE_LAT-1:0]     tag_vld;
    logic [PE_LAT-1:0]     tag_last;
    logic [ADDR_WIDTH-1:0] tag_au [PE_LAT];
    logic [ADDR_WIDTH-1:0] tag_av [PE_LAT];

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  tail_vld, tail_last;
    logic [ADDR_WIDTH-1:0] tail_au, tail_av;
    logic                  head_vld, head_bank, lo_bank, up_bank;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  pop, lo_grant, up_grant, push_lo, push_up;
    logic                  lo_ok, up_ok, drop;
    logic [CNT_W-1:0]      free_slots;
    logic [1:0]            grant_en;
    logic [ADDR_WIDTH-2:0] grant_row [2];
    logic [DATA_WIDTH-1:0] grant_data [2];
    logic                  pipe_busy, fifo_empty, done_cond;
    logic                  last_pend, cur_sel;

    assign tail_vld   = tag_vld[PE_LAT-1];
    assign tail_last  = tag_last[PE_LAT-1];
    assign tail_au    = tag_au[PE_LAT-1];
    assign tail_av    = tag_av[PE_LAT-1];
    assign pipe_busy  = |tag_vld;
    assign fifo_empty = (count == '0);
    assign idle       = !pipe_busy && fifo_empty;
    assign done_cond  = last_pend && !pipe_busy && fifo_empty && (grant_en == 2'b00);

    // Tag delay line: its tail lines up with the PE outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_last <= '0;
            for (int i = 0; i < PE_LAT; i++) begin
                tag_au[i] <= '0;
                tag_av[i] <= '0;
            end
        end else begin
            tag_vld  <= {tag_vld[PE_LAT-2:0], in_valid};
            tag_last <= {tag_last[PE_LAT-2:0], in_valid & in_last};
            for (int i = PE_LAT - 1; i > 0; i--) begin
                tag_au[i] <= tag_au[i-1];
                tag_av[i] <= tag_av[i-1];
            end
            tag_au[0] <= in_addr_u;
            tag_av[0] <= in_addr_v;
        end
    end

    // Per-bank grant (FIFO head > lower > upper) and FIFO push/drop decisions.
    always_comb begin
        head_vld  = !fifo_empty;
        head_addr = fifo_addr[rd_ptr];
        head_data = fifo_data[rd_ptr];
        head_bank = ^head_addr;
        lo_bank   = ^tail_au;
        up_bank   = ^tail_av;
        pop       = head_vld;
        lo_grant  = 1'b0;
        up_grant  = 1'b0;
        grant_en  = 2'b00;
        for (int b = 0; b < 2; b++) begin
            grant_row[b]  = '0;
            grant_data[b] = '0;
            if (head_vld && (head_bank == 1'(b))) begin
                grant_en[b]   = 1'b1;
                grant_row[b]  = head_addr[ADDR_WIDTH-1:1];
                grant_data[b] = head_data;
            end else if (tail_vld && (lo_bank == 1'(b))) begin
                grant_en[b]   = 1'b1;
                grant_row[b]  = tail_au[ADDR_WIDTH-1:1];
                grant_data[b] = bf_lower;
                lo_grant      = 1'b1;
            end else if (tail_vld && (up_bank == 1'(b))) begin
                grant_en[b]   = 1'b1;
                grant_row[b]  = tail_av[ADDR_WIDTH-1:1];
                grant_data[b] = bf_upper;
                up_grant      = 1'b1;
            end
        end
        push_lo = tail_vld && !lo_grant;
        push_up = tail_vld && !up_grant;
        // The head pops in the same cycle, so its slot is reusable for a push.
        free_slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        lo_ok = push_lo && (free_slots != '0);
        up_ok = push_up && (free_slots > CNT_W'(lo_ok));
        drop  = (push_lo && !lo_ok) || (push_up && !up_ok);
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (lo_ok) begin
            fifo_addr[wr_ptr] <= tail_au;
            fifo_data[wr_ptr] <= bf_lower;
        end
        if (up_ok) begin
            fifo_addr[wr_ptr + PTR_W'(lo_ok)] <= tail_av;
            fifo_data[wr_ptr + PTR_W'(lo_ok)] <= bf_upper;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(lo_ok) + PTR_W'(up_ok);
            count  <= count - CNT_W'(pop) + CNT_W'(lo_ok) + CNT_W'(up_ok);
        end
    end

    // Registered bank write ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr0_en   <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
            wr1_en   <= 1'b0;
            wr1_addr <= '0;
            wr1_data <= '0;
        end else begin
            wr0_en   <= grant_en[0];
            wr0_addr <= grant_row[0];
            wr0_data <= grant_data[0];
            wr1_en   <= grant_en[1];
            wr1_addr <= grant_row[1];
            wr1_data <= grant_data[1];
        end
    end

    // Stage completion tracking, mode consistency and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pend  <= 1'b0;
            stage_done <= 1'b0;
            cur_sel    <= 1'b0;
            mode_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            stage_done <= done_cond;
            if (tail_vld && tail_last)
                last_pend <= 1'b1;
            else if (done_cond)
                last_pend <= 1'b0;
            if (in_valid)
                cur_sel <= in_sel;
            if (in_valid && !idle && (in_sel != cur_sel))
                mode_err <= 1'b1;
            if (drop)
                ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf_writeback.sv
// Bench for bf_writeback: directed scenarios plus a randomized run, checked
// against a transaction-level model of issue, bank routing and the pending queue.
module tb_bf_writeback;

    localparam int DW    = 14;
    localparam int AW    = 8;
    localparam int LAT   = 9;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_sel = 1'b0, in_last = 1'b0;
    logic [AW-1:0] in_addr_u = '0, in_addr_v = '0;
    logic [DW-1:0] bf_lower = '0, bf_upper = '0;
    logic          wr0_en, wr1_en, idle, stage_done, mode_err, ovf_err;
    logic [AW-2:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;

    always #5 clk = ~clk;

    bf_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_last(in_last),
        .in_addr_u(in_addr_u), .in_addr_v(in_addr_v), .bf_lower(bf_lower), .bf_upper(bf_upper),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .idle(idle), .stage_done(stage_done), .mode_err(mode_err), .ovf_err(ovf_err)
    );

    typedef struct packed {
        logic [31:0]   stamp;
        logic          bank;
        logic [AW-2:0] row;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;
    typedef struct {
        bit            last;
        bit            sel;
        logic [AW-1:0] au, av;
        logic [DW-1:0] lo, up;
    } iss_t;

    iss_t issued [int];
    ent_t pend [$];
    wr_t  exp_wr [$], obs_wr [$];
    int   exp_sd [$], obs_sd [$];
    bit   exp_idle [$], obs_idle [$];
    bit   m_last_pend, m_cur_sel, m_mode, m_ovf;
    int   m_ovf_rise, obs_ovf_rise;
    int   cyc = 0, last_c = 0;
    int   checks = 0, errors = 0;

    // Log every bank write and stage_done pulse with the cycle it is visible in.
    always @(posedge clk) begin
        wr_t w;
        cyc++;
        #1;
        if (wr0_en === 1'b1) begin
            w = {32'(cyc), 1'b0, wr0_addr, wr0_data};
            obs_wr.push_back(w);
        end
        if (wr1_en === 1'b1) begin
            w = {32'(cyc), 1'b1, wr1_addr, wr1_data};
            obs_wr.push_back(w);
        end
        if (stage_done === 1'b1) obs_sd.push_back(cyc);
    end

    function automatic logic [DW-1:0] rdata();
        return DW'($urandom_range(0, 12288));
    endfunction

    // One cycle: predict this cycle's behaviour, then drive the issue inputs.
    task automatic step(input bit v, input bit s, input bit l, input logic [AW-1:0] au,
                        input logic [AW-1:0] av, input logic [DW-1:0] lo, input logic [DW-1:0] up);
        int   c;
        bit   busy, idle_m, sdc, b;
        bit   has [2];
        wr_t  wb [2];
        ent_t e;
        ent_t news [$];
        iss_t a;
        @(negedge clk);
        c = cyc;
        last_c = c;
        busy = 1'b0;
        for (int k = 1; k <= LAT; k++) if (issued.exists(c - k)) busy = 1'b1;
        idle_m = !busy && (pend.size() == 0);
        exp_idle.push_back(idle_m);
        obs_idle.push_back(idle);
        if (ovf_err === 1'b1 && obs_ovf_rise < 0) obs_ovf_rise = c;
        sdc = m_last_pend && idle_m;
        if (v && !idle_m && s != m_cur_sel) m_mode = 1'b1;
        if (v) m_cur_sel = s;
        has[0] = 1'b0;
        has[1] = 1'b0;
        if (pend.size() > 0) begin
            e = pend.pop_front();
            b = ^e.addr;
            has[b] = 1'b1;
            wb[b] = {32'(c + 1), b, e.addr[AW-1:1], e.data};
        end
        if (issued.exists(c - LAT)) begin
            a = issued[c - LAT];
            bf_lower = a.lo;
            bf_upper = a.up;
            for (int j = 0; j < 2; j++) begin
                e = (j == 0) ? {a.au, a.lo} : {a.av, a.up};
                b = ^e.addr;
                if (!has[b]) begin
                    has[b] = 1'b1;
                    wb[b] = {32'(c + 1), b, e.addr[AW-1:1], e.data};
                end else news.push_back(e);
            end
            foreach (news[j]) begin
                if (pend.size() < DEPTH) pend.push_back(news[j]);
                else begin
                    m_ovf = 1'b1;
                    if (m_ovf_rise < 0) m_ovf_rise = c + 1;
                end
            end
            if (a.last) m_last_pend = 1'b1;
            issued.delete(c - LAT);
        end else begin
            bf_lower = DW'($urandom);
            bf_upper = DW'($urandom);
        end
        if (sdc) begin
            m_last_pend = 1'b0;
            exp_sd.push_back(c + 1);
        end
        if (has[0]) exp_wr.push_back(wb[0]);
        if (has[1]) exp_wr.push_back(wb[1]);
        if (v) issued[c] = '{l, s, au, av, lo, up};
        in_valid = v; in_sel = s; in_last = l; in_addr_u = au; in_addr_v = av;
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issued.delete(); pend.delete();
        exp_wr.delete(); obs_wr.delete(); exp_sd.delete(); obs_sd.delete();
        exp_idle.delete(); obs_idle.delete();
        m_last_pend = 0; m_cur_sel = 0; m_mode = 0; m_ovf = 0;
        m_ovf_rise = -1; obs_ovf_rise = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        checks++;
        if ({wr0_en, wr1_en, stage_done, mode_err, ovf_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000", {wr0_en, wr1_en, stage_done, mode_err, ovf_err});
        end
        do_reset();
    endtask

    task automatic test_conflict_free();
        int  t;
        wr_t ex;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 14'd100, 14'd200);
        t = last_c;
        idle_steps(14);
        checks++;
        if (obs_wr.size() != 2) begin
            errors++; $display("FAIL cf_count got %0d want 2", obs_wr.size());
        end else begin
            ex = {32'(t + 10), 1'b0, 7'h00, 14'd100};
            checks++;
            if (obs_wr[0] !== ex) begin errors++; $display("FAIL cf_bank0 got %h want %h", obs_wr[0], ex); end
            ex = {32'(t + 10), 1'b1, 7'h00, 14'd200};
            checks++;
            if (obs_wr[1] !== ex) begin errors++; $display("FAIL cf_bank1 got %h want %h", obs_wr[1], ex); end
        end
    endtask

    task automatic test_same_bank();
        int  t;
        wr_t ex;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 14'd5, 14'd7);
        t = last_c;
        idle_steps(14);
        checks++;
        if (obs_wr.size() != 2) begin
            errors++; $display("FAIL sb_count got %0d want 2", obs_wr.size());
        end else begin
            ex = {32'(t + 10), 1'b0, 7'h00, 14'd5};
            checks++;
            if (obs_wr[0] !== ex) begin errors++; $display("FAIL sb_lower got %h want %h", obs_wr[0], ex); end
            ex = {32'(t + 11), 1'b0, 7'h01, 14'd7};
            checks++;
            if (obs_wr[1] !== ex) begin errors++; $display("FAIL sb_upper got %h want %h", obs_wr[1], ex); end
        end
    endtask

    task automatic test_overflow();
        int t0;
        logic [AW-1:0] au, av;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            au = AW'($urandom); if (^au) au[0] = ~au[0];
            av = AW'($urandom); if (^av) av[0] = ~av[0];
            step(1'b1, 1'b0, 1'b0, au, av, rdata(), rdata());
            if (i == 0) t0 = last_c;
        end
        idle_steps(20);
        checks++;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_err); end
        checks++;
        if (obs_ovf_rise != t0 + 14) begin errors++; $display("FAIL ovf_rise got %0d want %0d", obs_ovf_rise, t0 + 14); end
        checks++;
        if (obs_ovf_rise != m_ovf_rise) begin errors++; $display("FAIL ovf_rise_model got %0d want %0d", obs_ovf_rise, m_ovf_rise); end
        checks++;
        if (obs_wr.size() != 10 || exp_wr.size() != 10) begin
            errors++; $display("FAIL ovf_count got %0d want 10", obs_wr.size());
        end else foreach (exp_wr[i]) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL ovf_wr[%0d] got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
    endtask

    task automatic test_stage_done();
        int t;
        logic [AW-1:0] au;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            au = AW'($urandom);
            step(1'b1, 1'b0, (i == 15), au, au ^ 8'h01, rdata(), rdata());
        end
        t = last_c;
        idle_steps(16);
        checks++;
        if (obs_sd.size() != 1) begin
            errors++; $display("FAIL sd_count got %0d want 1", obs_sd.size());
        end else begin
            checks++;
            if (obs_sd[0] != t + 11) begin errors++; $display("FAIL sd_cycle got %0d want %0d", obs_sd[0], t + 11); end
            checks++;
            if (obs_wr.size() == 0 || obs_sd[0] != int'(obs_wr[$].stamp) + 1) begin
                errors++; $display("FAIL sd_after_last_write got %0d want last write + 1", obs_sd[0]);
            end
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            errors++; $display("FAIL sd_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        end else foreach (exp_wr[i]) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL sd_wr[%0d] got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        foreach (exp_idle[i]) begin
            checks++;
            if (obs_idle[i] !== exp_idle[i]) begin errors++; $display("FAIL sd_idle[%0d] got %b want %b", i, obs_idle[i], exp_idle[i]); end
        end
    endtask

    task automatic test_mode();
        logic [AW-1:0] au;
        do_reset();
        au = AW'($urandom);
        step(1'b1, 1'b0, 1'b0, au, au ^ 8'h01, rdata(), rdata());
        idle_steps(1);
        au = AW'($urandom);
        step(1'b1, 1'b1, 1'b0, au, au ^ 8'h01, rdata(), rdata());
        idle_steps(14);
        checks++;
        if (mode_err !== 1'b1) begin errors++; $display("FAIL mode_busy got %b want 1", mode_err); end
        checks++;
        if (obs_wr.size() != 4) begin errors++; $display("FAIL mode_busy_writes got %0d want 4", obs_wr.size()); end
        do_reset();
        step(1'b1, 1'b0, 1'b0, au, au ^ 8'h01, rdata(), rdata());
        idle_steps(12);
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL mode_idle_before got %b want 1", idle); end
        step(1'b1, 1'b1, 1'b0, au, au ^ 8'h01, rdata(), rdata());
        idle_steps(14);
        checks++;
        if (mode_err !== 1'b0 || m_mode) begin errors++; $display("FAIL mode_idle got %b want 0", mode_err); end
        checks++;
        if (obs_wr.size() != 4) begin errors++; $display("FAIL mode_idle_writes got %0d want 4", obs_wr.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, (i == 3), AW'($urandom), AW'($urandom), rdata(), rdata());
        idle_steps(3);
        do_reset();
        idle_steps(20);
        checks++;
        if (obs_wr.size() != 0) begin errors++; $display("FAIL rm_writes got %0d want 0", obs_wr.size()); end
        checks++;
        if (obs_sd.size() != 0) begin errors++; $display("FAIL rm_stage_done got %0d want 0", obs_sd.size()); end
        checks++;
        if ({idle, mode_err, ovf_err} !== 3'b100) begin
            errors++; $display("FAIL rm_status got %b want 100", {idle, mode_err, ovf_err});
        end
    endtask

    task automatic test_random();
        bit rs = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) rs = ~rs;
            step(($urandom_range(0, 9) < 6), rs, ($urandom_range(0, 15) == 0),
                 AW'($urandom), AW'($urandom), rdata(), rdata());
        end
        idle_steps(30);
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            errors++; $display("FAIL rnd_wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
        end else foreach (exp_wr[i]) begin
            checks++;
            if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rnd_wr[%0d] got %h want %h", i, obs_wr[i], exp_wr[i]); end
        end
        checks++;
        if (obs_sd != exp_sd) begin errors++; $display("FAIL rnd_stage_done got %0d pulses want %0d", obs_sd.size(), exp_sd.size()); end
        foreach (exp_idle[i]) begin
            checks++;
            if (obs_idle[i] !== exp_idle[i]) begin errors++; $display("FAIL rnd_idle[%0d] got %b want %b", i, obs_idle[i], exp_idle[i]); end
        end
        checks++;
        if (mode_err !== m_mode) begin errors++; $display("FAIL rnd_mode_err got %b want %b", mode_err, m_mode); end
        checks++;
        if (ovf_err !== m_ovf) begin errors++; $display("FAIL rnd_ovf_err got %b want %b", ovf_err, m_ovf); end
    endtask

    initial begin
        test_reset();
        test_conflict_free();
        test_same_bank();
        test_overflow();
        test_stage_done();
        test_mode();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
